// File: rtl/effect_xfade_slot.sv
// Wraps a fixed-latency effect and crossfades between the dry signal and the effect's wet return.
// The dry path is delayed to line up with the wet path, and the gain ramps over 2^RAMP_LOG2 samples.
module effect_xfade_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int FX_LATENCY = 7,
  parameter int RAMP_LOG2  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] audio_in,
  input  logic                         enable,
  output logic                         fx_in_valid,
  output logic signed [DATA_WIDTH-1:0] fx_in,
  input  logic                         fx_out_valid,
  input  logic signed [DATA_WIDTH-1:0] fx_out,
  output logic signed [DATA_WIDTH-1:0] audio_out,
  output logic                         audio_out_valid,
  output logic [1:0]                   state,
  output logic                         lat_err
);

  localparam int MW = DATA_WIDTH + RAMP_LOG2 + 2;
  localparam logic [RAMP_LOG2:0] FULL  = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [RAMP_LOG2:0] G_ONE = (RAMP_LOG2+1)'(1);

  typedef enum logic [1:0] {
    BYPASS   = 2'd0,
    FADE_IN  = 2'd1,
    WET      = 2'd2,
    FADE_OUT = 2'd3
  } xfade_state_t;

  xfade_state_t state_q, state_nx;
  logic [RAMP_LOG2:0] g_q, g_nx;

  logic                         dv_sr  [FX_LATENCY];
  logic signed [DATA_WIDTH-1:0] dry_sr [FX_LATENCY];
  logic                         dv;
  logic signed [DATA_WIDTH-1:0] dry;

  logic signed [MW-1:0]         wet_x, dry_x, g_x, gc_x, sum_x;
  logic signed [DATA_WIDTH-1:0] mix;

  assign dv  = dv_sr[FX_LATENCY-1];
  assign dry = dry_sr[FX_LATENCY-1];

  // Dry delay line, matched to the effect's latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FX_LATENCY; i++) begin
        dv_sr[i]  <= 1'b0;
        dry_sr[i] <= '0;
      end
    end else begin
      dv_sr[0]  <= sample_valid;
      dry_sr[0] <= audio_in;
      for (int unsigned i = 1; i < FX_LATENCY; i++) begin
        dv_sr[i]  <= dv_sr[i-1];
        dry_sr[i] <= dry_sr[i-1];
      end
    end
  end

  // Wet term is forced to zero in BYPASS so an absent or misbehaving effect cannot leak through
  always_comb begin
    wet_x = (state_q == BYPASS) ? '0 : MW'(fx_out);
    dry_x = MW'(dry);
    g_x   = MW'(g_q);
    gc_x  = MW'(FULL - g_q);
    sum_x = wet_x * g_x + dry_x * gc_x;
    mix   = DATA_WIDTH'(sum_x >>> RAMP_LOG2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
    end else begin
      audio_out_valid <= dv;
      if (dv) begin
        audio_out <= mix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BYPASS;
      g_q     <= '0;
      lat_err <= 1'b0;
    end else begin
      state_q <= state_nx;
      g_q     <= g_nx;
      if (state_q != BYPASS && fx_out_valid != dv) begin
        lat_err <= 1'b1;
      end
    end
  end

  // Gain steps in the direction of the current state; a reversal only takes effect next cycle
  always_comb begin
    state_nx = state_q;
    g_nx     = g_q;
    case (state_q)
      BYPASS: begin
        g_nx = '0;
        if (enable) state_nx = FADE_IN;
      end
      FADE_IN: begin
        if (dv && g_q != FULL) g_nx = g_q + G_ONE;
        if (!enable)           state_nx = FADE_OUT;
        else if (g_nx == FULL) state_nx = WET;
      end
      WET: begin
        g_nx = FULL;
        if (!enable) state_nx = FADE_OUT;
      end
      FADE_OUT: begin
        if (dv && g_q != '0) g_nx = g_q - G_ONE;
        if (enable)          state_nx = FADE_IN;
        else if (g_nx == '0) state_nx = BYPASS;
      end
      default: begin
        state_nx = BYPASS;
        g_nx     = '0;
      end
    endcase
  end

  always_comb begin
    fx_in_valid = sample_valid;
    fx_in       = audio_in;
    state       = state_q;
  end

endmodule

// File: tb/tb_effect_xfade_slot.sv
// Bench for effect_xfade_slot: a delayed-return effect stand-in, a per-cycle arithmetic model
// of the crossfade, and directed scenarios with literal expected sample sequences.
module tb_effect_xfade_slot;

  localparam int DW   = 32;
  localparam int LAT  = 7;
  localparam int RL   = 2;
  localparam int FULL = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 sample_valid = 1'b0;
  logic                 enable = 1'b0;
  logic signed [DW-1:0] audio_in = '0;
  logic signed [DW-1:0] wet_in = '0;
  logic                 late = 1'b0;

  logic                 fx_in_valid, fx_out_valid, audio_out_valid, lat_err;
  logic signed [DW-1:0] fx_in, fx_out, audio_out;
  logic [1:0]           state;

  logic                 pv [0:LAT];
  logic signed [DW-1:0] pd [0:LAT];

  int checks = 0;
  int failures = 0;
  logic signed [DW-1:0] outs [$];

  effect_xfade_slot #(
    .DATA_WIDTH(DW),
    .FX_LATENCY(LAT),
    .RAMP_LOG2(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .audio_in(audio_in),
    .enable(enable),
    .fx_in_valid(fx_in_valid),
    .fx_in(fx_in),
    .fx_out_valid(fx_out_valid),
    .fx_out(fx_out),
    .audio_out(audio_out),
    .audio_out_valid(audio_out_valid),
    .state(state),
    .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  // Effect stand-in: returns wet_in LAT clocks after the strobe, or LAT+1 when late is set
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= sample_valid;
      pd[0] <= wet_in;
      for (int i = 1; i <= LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign fx_out_valid = late ? pv[LAT] : pv[LAT-1];
  assign fx_out       = late ? pd[LAT] : pd[LAT-1];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model: 0 BYPASS, 1 FADE_IN, 2 WET, 3 FADE_OUT
  int     m_state = 0;
  int     m_g = 0;
  bit     m_err = 1'b0;
  bit     m_vld = 1'b0;
  longint m_out = 0;
  bit     mv [LAT];
  longint md [LAT];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0;
      m_g     = 0;
      m_err   = 1'b0;
      m_vld   = 1'b0;
      m_out   = 0;
      for (int i = 0; i < LAT; i++) begin
        mv[i] = 1'b0;
        md[i] = 0;
      end
    end else begin
      bit     d;
      longint dry_s;
      int     g_new;
      int     nxt;
      d     = mv[LAT-1];
      dry_s = md[LAT-1];
      if (d) m_out = floor_div(longint'(fx_out) * m_g + dry_s * (FULL - m_g), FULL);
      m_vld = d;
      if (m_state != 0 && fx_out_valid != d) m_err = 1'b1;
      g_new = m_g;
      if (d && m_state == 1) g_new = (m_g < FULL) ? m_g + 1 : FULL;
      if (d && m_state == 3) g_new = (m_g > 0) ? m_g - 1 : 0;
      if (m_state == 0) g_new = 0;
      if (m_state == 2) g_new = FULL;
      nxt = m_state;
      case (m_state)
        0: if (enable) nxt = 1;
        1: if (!enable) nxt = 3; else if (g_new == FULL) nxt = 2;
        2: if (!enable) nxt = 3;
        3: if (enable) nxt = 1; else if (g_new == 0) nxt = 0;
        default: nxt = 0;
      endcase
      m_state = nxt;
      m_g     = g_new;
      for (int i = LAT - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = sample_valid;
      md[0] = longint'(audio_in);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_valid", audio_out_valid, m_vld);
    chk("cyc_audio_out", audio_out, m_out);
    chk("cyc_state", state, m_state);
    chk("cyc_lat_err", lat_err, m_err);
    if (audio_out_valid === 1'b1) outs.push_back(audio_out);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int dry_v, input int wet_v);
    @(negedge clk);
    sample_valid = 1'b1;
    audio_in     = dry_v;
    wet_in       = wet_v;
    @(negedge clk);
    sample_valid = 1'b0;
    tick(1);
  endtask

  task automatic drain();
    tick(LAT + 4);
  endtask

  task automatic expect_out(input string name, input int exp);
    if (outs.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got no output expected %0d", name, exp);
    end else begin
      chk(name, outs.pop_front(), exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    tick(2);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_valid", audio_out_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_lat_err", lat_err, 0);
    rst = 1'b1;
    tick(2);

    // Bypass: dry passes bit-exact after FX_LATENCY+1 clocks, wet ignored
    outs.delete();
    @(negedge clk);
    sample_valid = 1'b1;
    audio_in     = 1000;
    wet_in       = 12345;
    #1;
    chk("fx_in_valid", fx_in_valid, 1);
    chk("fx_in", fx_in, 1000);
    @(negedge clk);
    sample_valid = 1'b0;
    n = 1;
    while (audio_out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bypass_latency", n, 8);
    expect_out("bypass_value", 1000);
    tick(4);

    // Fade in to WET
    enable = 1'b1;
    tick(1);
    outs.delete();
    for (int i = 0; i < 5; i++) send(1000, -1000);
    drain();
    expect_out("fade_in0", 1000);
    expect_out("fade_in1", 500);
    expect_out("fade_in2", 0);
    expect_out("fade_in3", -500);
    expect_out("fade_in4", -1000);
    chk("fade_in_extra", outs.size(), 0);
    chk("state_wet", state, 2);

    // Fade out to BYPASS
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send(1000, -1000);
    drain();
    expect_out("fade_out0", -1000);
    expect_out("fade_out1", -500);
    expect_out("fade_out2", 0);
    expect_out("fade_out3", 500);
    chk("state_bypass_a", state, 0);

    // Reverse mid-fade at g=2
    enable = 1'b1;
    send(1000, -1000);
    send(1000, -1000);
    drain();
    expect_out("rev_in0", 1000);
    expect_out("rev_in1", 500);
    chk("state_fade_in", state, 1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send(1000, -1000);
    drain();
    expect_out("rev_out0", 0);
    expect_out("rev_out1", 500);
    expect_out("rev_out2", 1000);
    chk("state_bypass_b", state, 0);

    // Floor rounding at g=1 for positive and negative dry
    enable = 1'b1;
    send(5, 5);
    send(1, 0);
    drain();
    enable = 1'b0;
    send(8, 0);
    drain();
    enable = 1'b1;
    send(-1, 0);
    drain();
    enable = 1'b0;
    send(4, 0);
    send(4, 0);
    drain();
    expect_out("floor0", 5);
    expect_out("floor_pos", 0);
    expect_out("floor2", 4);
    expect_out("floor_neg", -1);
    expect_out("floor4", 2);
    expect_out("floor5", 3);
    chk("state_bypass_c", state, 0);

    // Late effect return in WET sets sticky lat_err
    enable = 1'b1;
    for (int i = 0; i < 4; i++) send(100, 200);
    drain();
    expect_out("mix0", 100);
    expect_out("mix1", 125);
    expect_out("mix2", 150);
    expect_out("mix3", 175);
    chk("state_wet_b", state, 2);
    chk("lat_err_clean", lat_err, 0);
    late = 1'b1;
    send(100, 200);
    drain();
    chk("lat_err_set", lat_err, 1);
    late = 1'b0;
    tick(20);
    chk("lat_err_sticky", lat_err, 1);

    // Back to FADE_IN at g=2, then asynchronous reset
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send(1000, -1000);
    drain();
    chk("state_bypass_d", state, 0);
    enable = 1'b1;
    outs.delete();
    send(1000, -1000);
    send(1000, -1000);
    drain();
    expect_out("pre_rst0", 1000);
    expect_out("pre_rst1", 500);
    chk("pre_rst_state", state, 1);
    chk("pre_rst_lat_err", lat_err, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_audio_out", audio_out, 0);
    chk("arst_valid", audio_out_valid, 0);
    chk("arst_state", state, 0);
    chk("arst_lat_err", lat_err, 0);
    tick(2);
    rst = 1'b1;
    outs.delete();
    for (int i = 0; i < 3; i++) send(1000, -1000);
    drain();
    expect_out("post_rst0", 1000);
    expect_out("post_rst1", 500);
    expect_out("post_rst2", 0);
    chk("post_rst_state", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/effect_xfade_slot.md
EFFECT_XFADE_SLOT -- requirements
Module: effect_xfade_slot

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed sample width.
REQ-002 SHALL have parameter FX_LATENCY, default 7: fixed latency of the attached effect in clocks, range 1..64.
REQ-003 SHALL have parameter RAMP_LOG2, default 8: crossfade length of 2^RAMP_LOG2 samples, range 1..12.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sample_valid, input, 1: input sample strobe.
REQ-007 SHALL have port audio_in, input, DATA_WIDTH signed: dry input sample.
REQ-008 SHALL have port enable, input, 1: effect requested on.
REQ-009 SHALL have port fx_in_valid, output, 1: strobe to the effect.
REQ-010 SHALL have port fx_in, output, DATA_WIDTH signed: sample to the effect.
REQ-011 SHALL have port fx_out_valid, input, 1: strobe from the effect.
REQ-012 SHALL have port fx_out, input, DATA_WIDTH signed: wet sample from the effect.
REQ-013 SHALL have port audio_out, output, DATA_WIDTH signed: mixed output sample.
REQ-014 SHALL have port audio_out_valid, output, 1: output strobe.
REQ-015 SHALL have port state, output, 2: 0 BYPASS, 1 FADE_IN, 2 WET, 3 FADE_OUT.
REQ-016 SHALL have port lat_err, output, 1: sticky effect-latency mismatch flag.

Function
REQ-017 SHALL drive fx_in_valid and fx_in combinationally equal to sample_valid and audio_in.
REQ-018 SHALL delay sample_valid and audio_in by exactly FX_LATENCY clocks in a dry shift register; the delayed strobe is dv and the delayed sample is dry.
REQ-019 SHALL hold a gain g, an unsigned value in 0..FULL where FULL = 2^RAMP_LOG2.
REQ-020 SHALL compute mix = (fx_out*g + dry*(FULL-g)) >>> RAMP_LOG2 as an arithmetic shift (floor) at width DATA_WIDTH+RAMP_LOG2+2; no saturation, since the result is a convex combination.
REQ-021 SHALL register audio_out <= mix and audio_out_valid <= dv on every clock, giving a total latency of FX_LATENCY+1 clocks from sample_valid; audio_out SHALL hold its value while dv=0.
REQ-022 SHALL use g before its update when forming mix.
REQ-023 SHALL, in BYPASS, hold g=0; on enable=1, move to FADE_IN at the next edge regardless of dv.
REQ-024 SHALL, in FADE_IN, increment g on each dv; when the post-step g equals FULL and enable=1, move to WET.
REQ-025 SHALL, in WET, hold g=FULL; on enable=0, move to FADE_OUT at the next edge.
REQ-026 SHALL, in FADE_OUT, decrement g on each dv; when the post-step g equals 0 and enable=0, move to BYPASS.
REQ-027 SHALL, on enable=0 in FADE_IN, move to FADE_OUT and SHALL, on enable=1 in FADE_OUT, move to FADE_IN, continuing from the current g with no jump; if dv coincides, the g step uses the old state.
REQ-028 SHALL saturate g at its endpoints: no increment past FULL, no decrement below 0.
REQ-029 SHALL set lat_err when state != BYPASS and fx_out_valid != dv in any cycle; lat_err is cleared only by reset.
REQ-030 SHALL ignore fx_out and fx_out_valid entirely in BYPASS (g=0), so the dry sample passes bit-exact.

Reset
REQ-031 SHALL, while rst=0, asynchronously force state=BYPASS, g=0, the dry shift register to all zero, audio_out=0, audio_out_valid=0 and lat_err=0.
REQ-032 SHALL, after rst is released mid-fade, restart from BYPASS/g=0; when enable=1, the first sample after release starts the fade from g=0.

Verification
REQ-033 SHALL pass this scenario: bypass, FX_LATENCY=7, audio_in=1000 strobe -> audio_out=1000 with audio_out_valid high exactly 8 clocks later.
REQ-034 SHALL pass this scenario: RAMP_LOG2=2, enable=1, dry=1000 and wet=-1000 per sample -> outputs 1000, 500, 0, -500, -1000, then state=WET.
REQ-035 SHALL pass this scenario: the same setup with enable dropped after two fade samples (g=2) -> outputs 0, 500, 1000, then state=BYPASS, with no discontinuity.
REQ-036 SHALL pass this scenario: RAMP_LOG2=2, g=1, dry=1 and wet=0 -> output 0; dry=-1 and wet=0 -> output -1 (floor rounding).
REQ-037 SHALL pass this scenario: in WET, fx_out_valid is one clock late -> lat_err=1 and it stays 1 until rst=0.
REQ-038 SHALL pass this scenario: rst pulsed low at g=2 in FADE_IN -> all outputs 0 immediately (asynchronously); after release with enable=1, the next outputs follow g=0,1,2...
